// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions for the unified memory port.
// Latency: none (types and constants only).
// Backpressure: n/a.
// Contents: arbiter state encoding, decodable by the hazard unit and benches,
//           and the request-type constants used when a request is issued.
package riscv_pipe_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DBUSY = 3'd1,
      IBUSY = 3'd2,
      DRESP = 3'd3,
      IRESP = 3'd4
   } mem_arb_state_t;

   // Request type of the access currently being issued to memory.
   localparam logic MEM_REQ_INST = 1'b0;
   localparam logic MEM_REQ_DATA = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (F) and data access (M).
// Latency: request sampled in cycle 0, MemReq from cycle 1, Done one cycle after MemReady.
// Backpressure: MemReq held until MemReady; F/M held via StallFetch/StallPipe until Done.
//
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   IReqF, PCF, FlushF             fetch request, fetch address, fetch redirect
//   DReqM, MemWriteM, ALUResultM,
//   WriteDataM                     M-stage load/store request
//   MemReq, MemWE, MemAddr,
//   MemWData, MemReady, MemRData   request/ready handshake toward memory
//   InstrF, InstDone               fetched instruction and its completion pulse
//   ReadDataM, DataDone            load data and its completion pulse
//   StallFetch, StallPipe          stall requests to the hazard unit
module mem_port_arbiter
   import riscv_pipe_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              IReqF,
   input  logic [ADDR_W-1:0] PCF,
   input  logic              FlushF,
   input  logic              DReqM,
   input  logic              MemWriteM,
   input  logic [ADDR_W-1:0] ALUResultM,
   input  logic [DATA_W-1:0] WriteDataM,
   output logic              MemReq,
   output logic              MemWE,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [DATA_W-1:0] MemWData,
   input  logic              MemReady,
   input  logic [DATA_W-1:0] MemRData,
   output logic [DATA_W-1:0] InstrF,
   output logic              InstDone,
   output logic [DATA_W-1:0] ReadDataM,
   output logic              DataDone,
   output logic              StallFetch,
   output logic              StallPipe
);

   mem_arb_state_t    state, state_nxt;
   logic              drop, drop_nxt;
   logic              req_nxt, we_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [DATA_W-1:0] wdata_nxt, instr_nxt, rdata_nxt;
   logic              issue_kind;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         drop      <= 1'b0;
         MemReq    <= 1'b0;
         MemWE     <= 1'b0;
         MemAddr   <= '0;
         MemWData  <= '0;
         InstrF    <= '0;
         ReadDataM <= '0;
      end else begin
         state     <= state_nxt;
         drop      <= drop_nxt;
         MemReq    <= req_nxt;
         MemWE     <= we_nxt;
         MemAddr   <= addr_nxt;
         MemWData  <= wdata_nxt;
         InstrF    <= instr_nxt;
         ReadDataM <= rdata_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      drop_nxt   = drop;
      req_nxt    = MemReq;
      we_nxt     = MemWE;
      addr_nxt   = MemAddr;
      wdata_nxt  = MemWData;
      instr_nxt  = InstrF;
      rdata_nxt  = ReadDataM;
      // Data wins a tie: it belongs to the older instruction.
      issue_kind = DReqM ? MEM_REQ_DATA : MEM_REQ_INST;

      unique case (state)
         IDLE: begin
            if (DReqM || IReqF) begin
               req_nxt = 1'b1;
               if (issue_kind == MEM_REQ_DATA) begin
                  state_nxt = DBUSY;
                  we_nxt    = MemWriteM;
                  addr_nxt  = ALUResultM;
                  wdata_nxt = WriteDataM;
               end else begin
                  state_nxt = IBUSY;
                  we_nxt    = 1'b0;
                  addr_nxt  = PCF;
                  wdata_nxt = '0;
                  // A redirect in the issue cycle already makes this fetch stale.
                  drop_nxt  = FlushF;
               end
            end
         end
         DBUSY: begin
            if (MemReady) begin
               state_nxt = DRESP;
               req_nxt   = 1'b0;
               rdata_nxt = MemRData;
            end
         end
         IBUSY: begin
            if (MemReady) begin
               req_nxt  = 1'b0;
               drop_nxt = 1'b0;
               // A redirect coinciding with the completion also discards it.
               if (drop || FlushF) begin
                  state_nxt = IDLE;
               end else begin
                  state_nxt = IRESP;
                  instr_nxt = MemRData;
               end
            end else if (FlushF) begin
               drop_nxt = 1'b1;
            end
         end
         DRESP:   state_nxt = IDLE;
         IRESP:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign DataDone   = (state == DRESP);
   assign InstDone   = (state == IRESP) && !FlushF;
   assign StallFetch = IReqF && !InstDone;
   assign StallPipe  = DReqM && !DataDone;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
// The model tracks the outstanding access and the cycles its response and release fall on.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        IReqF = 1'b0, FlushF = 1'b0, DReqM = 1'b0, MemWriteM = 1'b0;
   logic [31:0] PCF = '0, ALUResultM = '0, WriteDataM = '0, MemRData = '0;
   logic        MemReady = 1'b0;
   logic        MemReq, MemWE, InstDone, DataDone, StallFetch, StallPipe;
   logic [31:0] MemAddr, MemWData, InstrF, ReadDataM;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .IReqF(IReqF), .PCF(PCF), .FlushF(FlushF),
      .DReqM(DReqM), .MemWriteM(MemWriteM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .MemReq(MemReq), .MemWE(MemWE), .MemAddr(MemAddr), .MemWData(MemWData),
      .MemReady(MemReady), .MemRData(MemRData),
      .InstrF(InstrF), .InstDone(InstDone), .ReadDataM(ReadDataM), .DataDone(DataDone),
      .StallFetch(StallFetch), .StallPipe(StallPipe)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, exp);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   logic        cmp_on = 1'b0;
   int          mcyc = 0, resp_cyc = -1, free_cyc = 0;
   logic        m_active = 1'b0, m_isdata = 1'b0, m_we = 1'b0, m_drop = 1'b0, resp_isdata = 1'b0;
   logic [31:0] m_addr = '0, m_wdata = '0, m_instr = '0, m_rdata = '0;

   always @(negedge clk) begin
      logic ed, ei;
      if (cmp_on) begin
         ed = (resp_cyc == mcyc) && resp_isdata;
         ei = (resp_cyc == mcyc) && !resp_isdata && !FlushF;
         chk("model_memreq", MemReq, m_active);
         if (m_active) begin
            chk("model_memaddr", MemAddr, m_addr);
            chk("model_memwe", MemWE, m_we);
            chk("model_memwdata", MemWData, m_wdata);
         end
         chk("model_datadone", DataDone, ed);
         chk("model_instdone", InstDone, ei);
         chk("model_instrf", InstrF, m_instr);
         chk("model_readdatam", ReadDataM, m_rdata);
         chk("model_stallfetch", StallFetch, IReqF && !ei);
         chk("model_stallpipe", StallPipe, DReqM && !ed);
      end
      // Advance the model by the edge that follows this cycle.
      if (rst) begin
         m_active = 1'b0; m_drop = 1'b0; m_instr = '0; m_rdata = '0;
         resp_cyc = -1; free_cyc = mcyc + 1; cmp_on = 1'b1;
      end else if (m_active) begin
         if (MemReady) begin
            m_active = 1'b0;
            if (m_isdata) begin
               m_rdata = MemRData; resp_isdata = 1'b1;
               resp_cyc = mcyc + 1; free_cyc = mcyc + 2;
            end else if (m_drop || FlushF) begin
               free_cyc = mcyc + 1;
            end else begin
               m_instr = MemRData; resp_isdata = 1'b0;
               resp_cyc = mcyc + 1; free_cyc = mcyc + 2;
            end
         end else if (!m_isdata && FlushF) begin
            m_drop = 1'b1;
         end
      end else if (mcyc >= free_cyc) begin
         if (DReqM) begin
            m_active = 1'b1; m_isdata = 1'b1; m_we = MemWriteM;
            m_addr = ALUResultM; m_wdata = WriteDataM; m_drop = 1'b0;
         end else if (IReqF) begin
            m_active = 1'b1; m_isdata = 1'b0; m_we = 1'b0;
            m_addr = PCF; m_wdata = '0; m_drop = FlushF;
         end
      end
      mcyc++;
   end

   // Counters for the zero-wait run: Done pulses and MemReq rising edges.
   logic cnt_on = 1'b0, prev_req = 1'b0;
   int   done_cnt = 0, req_cnt = 0;
   always @(negedge clk) begin
      if (cnt_on) begin
         if (InstDone || DataDone) done_cnt++;
         if (MemReq && !prev_req) req_cnt++;
      end
      prev_req = MemReq;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      IReqF = 1'b0; DReqM = 1'b0; FlushF = 1'b0; MemWriteM = 1'b0;
      MemReady = 1'b0; WriteDataM = '0;
   endtask

   initial begin
      logic [31:0] v;
      step(); step();
      rst = 1'b0;
      step();
      #1;
      chk("reset_memreq", MemReq, 1'b0);
      chk("reset_memaddr", MemAddr, 32'h0);
      chk("reset_instrf", InstrF, 32'h0);
      chk("reset_done", {InstDone, DataDone}, 2'b00);

      // Fetch only.
      step(); IReqF = 1'b1; PCF = 32'h100;                  // c0
      #1 chk("f_stall_c0", StallFetch, 1'b1);
      step(); #1 chk("f_req_c1", MemReq, 1'b1);             // c1
      chk("f_addr_c1", MemAddr, 32'h100);
      step(); #1 chk("f_req_c2", MemReq, 1'b1);             // c2
      step(); MemReady = 1'b1; MemRData = 32'h00500093;     // c3
      #1 chk("f_req_c3", MemReq, 1'b1);
      step(); MemReady = 1'b0;                              // c4
      #1 chk("f_done_c4", InstDone, 1'b1);
      chk("f_instr_c4", InstrF, 32'h00500093);
      chk("f_stall_c4", StallFetch, 1'b0);
      step(); idle_inputs();                                // c5

      // Simultaneous fetch and load: data first.
      step(); IReqF = 1'b1; PCF = 32'h104; DReqM = 1'b1; ALUResultM = 32'h2000;
      step(); #1 chk("s_daddr", MemAddr, 32'h2000);         // c1
      chk("s_dwe", MemWE, 1'b0);
      step(); #1 chk("s_fstall_c2", StallFetch, 1'b1);      // c2
      step(); MemReady = 1'b1; MemRData = 32'h11112222;     // c3
      step(); MemReady = 1'b0;                              // c4
      #1 chk("s_ddone", DataDone, 1'b1);
      chk("s_rdata", ReadDataM, 32'h11112222);
      chk("s_fstall_c4", StallFetch, 1'b1);
      chk("s_pstall_c4", StallPipe, 1'b0);
      step(); DReqM = 1'b0;                                 // c5
      step(); #1 chk("s_iaddr", MemAddr, 32'h104);          // c6
      chk("s_iwdata", MemWData, 32'h0);
      step();                                               // c7
      step(); MemReady = 1'b1; MemRData = 32'h00A00113;     // c8
      step(); MemReady = 1'b0;                              // c9
      #1 chk("s_idone", InstDone, 1'b1);
      chk("s_instr", InstrF, 32'h00A00113);
      step(); idle_inputs();

      // Store.
      step(); DReqM = 1'b1; MemWriteM = 1'b1; ALUResultM = 32'h2004; WriteDataM = 32'hDEADBEEF;
      #1 chk("st_pstall_c0", StallPipe, 1'b1);
      step(); #1 chk("st_we_c1", MemWE, 1'b1);
      chk("st_wdata_c1", MemWData, 32'hDEADBEEF);
      step(); #1 chk("st_addr_c2", MemAddr, 32'h2004);
      chk("st_wdata_c2", MemWData, 32'hDEADBEEF);
      step(); MemReady = 1'b1; MemRData = 32'h55AA55AA;     // c3
      #1 chk("st_pstall_c3", StallPipe, 1'b1);
      step(); MemReady = 1'b0;                              // c4
      #1 chk("st_done", DataDone, 1'b1);
      chk("st_pstall_c4", StallPipe, 1'b0);
      step(); idle_inputs();

      // Flush while the fetch is in flight.
      step(); IReqF = 1'b1; PCF = 32'h108;                  // c0
      step(); #1 chk("fl_addr", MemAddr, 32'h108);          // c1
      step(); FlushF = 1'b1; PCF = 32'h200;                 // c2
      step(); FlushF = 1'b0;                                // c3
      step(); MemReady = 1'b1; MemRData = 32'hBAD0BAD0;     // c4
      step(); MemReady = 1'b0;                              // c5
      #1 chk("fl_nodone", InstDone, 1'b0);
      chk("fl_idle_req", MemReq, 1'b0);
      chk("fl_instr_held", InstrF, 32'h00A00113);
      step(); MemReady = 1'b1; MemRData = 32'h00C00193;     // c6
      #1 chk("fl_newaddr", MemAddr, 32'h200);
      chk("fl_newreq", MemReq, 1'b1);
      step(); MemReady = 1'b0;                              // c7
      #1 chk("fl_newdone", InstDone, 1'b1);
      chk("fl_newinstr", InstrF, 32'h00C00193);
      step(); idle_inputs();

      // Reset in the middle of a data access.
      step(); DReqM = 1'b1; ALUResultM = 32'h3000;          // c0
      step(); #1 chk("r_busy", MemReq, 1'b1);               // c1
      step(); rst = 1'b1;                                   // c2
      step(); rst = 1'b0; DReqM = 1'b0; MemReady = 1'b1; MemRData = 32'h77777777;
      #1 chk("r_memreq", MemReq, 1'b0);
      chk("r_memwe", MemWE, 1'b0);
      chk("r_memaddr", MemAddr, 32'h0);
      chk("r_memwdata", MemWData, 32'h0);
      chk("r_instrf", InstrF, 32'h0);
      chk("r_readdata", ReadDataM, 32'h0);
      chk("r_dones", {InstDone, DataDone}, 2'b00);
      step(); MemReady = 1'b0;                              // c4
      #1 chk("r_stale_ignored", {DataDone, MemReq}, 2'b00);
      chk("r_stale_rdata", ReadDataM, 32'h0);
      step(); idle_inputs();

      // Zero-wait memory: alternating loads and fetches.
      cnt_on = 1'b1;
      for (int i = 0; i < 10; i++) begin
         v = 32'hA000_0000 + i;
         step(); MemReady = 1'b0;                           // c0
         DReqM = (i % 2 == 0); IReqF = (i % 2 != 0);
         ALUResultM = 32'h4000 + 4 * i; PCF = 32'h300 + 4 * i;
         step(); MemReady = 1'b1; MemRData = v;             // c1
         #1 chk("z_req", MemReq, 1'b1);
         chk("z_addr", MemAddr, (i % 2 == 0) ? 32'h4000 + 4 * i : 32'h300 + 4 * i);
         step(); MemReady = 1'b0;                           // c2
         #1 if (i % 2 == 0) begin
            chk("z_ddone", DataDone, 1'b1);
            chk("z_rdata", ReadDataM, v);
         end else begin
            chk("z_idone", InstDone, 1'b1);
            chk("z_instr", InstrF, v);
         end
      end
      step(); idle_inputs();
      step(); step();
      cnt_on = 1'b0;
      chk("z_done_count", done_cnt, 32'd10);
      chk("z_req_count", req_cnt, 32'd10);

      // Randomized traffic; the model checks every cycle.
      for (int k = 0; k < 3000; k++) begin
         step();
         rst        = ($urandom_range(0, 199) == 0);
         IReqF      = ($urandom_range(0, 9) < 6);
         DReqM      = ($urandom_range(0, 9) < 3);
         FlushF     = ($urandom_range(0, 9) == 0);
         MemWriteM  = $urandom_range(0, 1);
         PCF        = $urandom;
         ALUResultM = $urandom;
         WriteDataM = $urandom;
         MemRData   = $urandom;
         if (MemReq) MemReady = ($urandom_range(0, 9) < 4);
         else        MemReady = ($urandom_range(0, 9) == 0);
      end
      step(); idle_inputs(); rst = 1'b0;
      step(); step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares the pipeline's single unified memory port between the instruction-fetch stage and the memory stage. It runs a request/ready handshake toward a variable-latency memory. It returns the fetched instruction and load data. It drives the stall signals that the hazard unit combines with its own lwStall/flush logic. It sits between the F/M pipeline stages and the memory model.

## Interface
- ADDR_W, 32, memory address width
- DATA_W, 32, memory data width
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- IReqF  input  1  fetch stage wants an instruction at PCF
- PCF  input  ADDR_W  fetch address
- FlushF  input  1  fetch redirect (PCSrcE); in-flight fetch is discarded
- DReqM  input  1  M stage has a load or store
- MemWriteM  input  1  1 = store, 0 = load
- ALUResultM  input  ADDR_W  data address
- WriteDataM  input  DATA_W  store data
- MemReq  output  1  request to memory, held until MemReady
- MemWE  output  1  write enable, valid with MemReq
- MemAddr  output  ADDR_W  request address
- MemWData  output  DATA_W  write data
- MemReady  input  1  one-cycle completion pulse from memory
- MemRData  input  DATA_W  read data, valid with MemReady
- InstrF  output  DATA_W  fetched instruction, valid when InstDone
- InstDone  output  1  one-cycle pulse, fetch complete
- ReadDataM  output  DATA_W  load data, valid when DataDone
- DataDone  output  1  one-cycle pulse, data access complete
- StallFetch  output  1  IReqF & ~InstDone; the F stage holds and the D stage takes a bubble
- StallPipe  output  1  DReqM & ~DataDone; all stages F..W freeze

## Operation
- FSM states: IDLE, DBUSY, IBUSY, DRESP, IRESP.
- IDLE → DBUSY if DReqM. Data has priority because it belongs to the older instruction.
  - Otherwise IDLE → IBUSY if IReqF.
  - Otherwise IDLE holds.
- On entering DBUSY or IBUSY, register the request: MemReq=1, MemAddr, MemWE and MemWData. For a fetch, MemWE=0 and MemWData=0.
- MemAddr, MemWE and MemWData stay constant while MemReq=1.
- DBUSY: on MemReady → DRESP, MemReq=0, latch MemRData into ReadDataM. Stores also complete this way; the ReadDataM value is don't-care for stores.
- IBUSY: on MemReady → IRESP, MemReq=0, latch MemRData into InstrF. If the drop flag is set, go to IDLE instead and suppress InstDone.
- Drop flag: set by FlushF in IBUSY, or by FlushF in the same cycle the fetch is issued from IDLE. Cleared on leaving IBUSY.
- DRESP: DataDone=1 for exactly one cycle, then → IDLE. DReqM is not sampled in DRESP, so the completed access is never re-issued.
- IRESP: InstDone=1 for exactly one cycle, then → IDLE. FlushF during IRESP forces InstDone=0.
- ReadDataM and InstrF hold their last value between completions.
- Reset values: state IDLE, MemReq=0, MemWE=0, MemAddr=0, MemWData=0, InstrF=0, ReadDataM=0, InstDone=0, DataDone=0, drop=0.

## Timing
- Request sampled in IDLE at cycle 0. MemReq rises at cycle 1.
- Memory may assert MemReady in cycle 1 at the earliest.
- If MemReady arrives at cycle N, the Done pulse and valid data occur at cycle N+1, and the state is IDLE at cycle N+2.
- Minimum access: 3 cycles from request to next IDLE. Back-to-back accesses are spaced 3 cycles apart at best.
- StallFetch and StallPipe are combinational from inputs and the Done flops. They deassert in the Done cycle, so the pipeline advances exactly once per completion.
- Simultaneous IReqF and DReqM in IDLE: data is served first; the fetch waits, with StallFetch held.
- Data requests cannot starve fetch indefinitely, because each new DReqM requires a fetched instruction.
- MemReady outside DBUSY/IBUSY is ignored.
- Reset mid-access: the transaction is abandoned and MemReq drops next cycle. The memory model must tolerate a request withdrawn before completion.

## Structure
- Put the state enum (IDLE, DBUSY, IBUSY, DRESP, IRESP) in the shared pipeline package riscv_pipe_pkg, so the hazard unit and benches can decode it.
- Put a MEM_REQ_INST/MEM_REQ_DATA request-type constant in the same package.
- Single module; no sub-module is needed. The request register set (address, write enable, write data) is kept inline.

## Test plan
- Fetch only: IReqF=1, PCF=0x100, MemReady at cycle 3 with 0x00500093 → MemReq=1 in cycles 1–3, MemAddr=0x100, InstDone and InstrF=0x00500093 at cycle 4, StallFetch=0 at cycle 4.
- Simultaneous requests: IReqF=1 (PCF=0x104), DReqM=1 load (ALUResultM=0x2000), MemReady 2 cycles after each MemReq → data issued first with MemAddr=0x2000, DataDone, then fetch with MemAddr=0x104. StallFetch stays high throughout the data access.
- Store: DReqM=1, MemWriteM=1, ALUResultM=0x2004, WriteDataM=0xDEADBEEF → MemWE=1 and MemWData=0xDEADBEEF held until MemReady, then a DataDone pulse. StallPipe is high from cycle 0 until the DataDone cycle.
- Flush in flight: fetch at 0x108 issued, FlushF pulsed at cycle 2, MemReady at cycle 4 → no InstDone, IDLE at cycle 5, and a new fetch at the redirect PC issues cleanly.
- Reset mid-access: rst asserted while in DBUSY → next cycle all outputs are at reset values and MemReq=0. A MemReady arriving after reset is ignored.
- Zero-wait memory: MemReady arrives in the same cycle MemReq rises, for 10 alternating loads and fetches → every access completes in exactly 3 cycles, with exactly one Done pulse per access and no duplicated requests.
